// File: rtl/ir_frontend.sv
// IR receiver front end: synchronizer, glitch filter, edge-realigned sample
// prescaler, idle detection and frame-start flag for the downstream decoder.
module ir_frontend #(
   parameter int unsigned DIV        = 28125,
   parameter int unsigned FILT       = 8,
   parameter int unsigned IDLE_TICKS = 32,
   parameter int unsigned INVERT     = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic ir_in,
   output logic ir_sample,
   output logic sample_clk,
   output logic sample_tick,
   output logic idle,
   output logic frame_start
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned FW = (FILT > 1) ? $clog2(FILT) : 1;
   localparam int unsigned IW = $clog2(IDLE_TICKS + 1);

   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2);
   localparam logic [CW-1:0] CNT_RISE  = CW'(DIV / 2 - 1);
   localparam logic [FW-1:0] FCNT_LAST = FW'(FILT - 1);
   localparam logic [IW-1:0] IDLE_FULL = IW'(IDLE_TICKS);

   localparam logic INV_BIT  = (INVERT != 0);
   // Synchronizer flops reset to the raw level that reads as line-high.
   localparam logic SYNC_RST = ~INV_BIT;

   logic          sync1, sync2, s;
   logic          filt;
   logic [FW-1:0] fcnt;
   logic          filt_edge, filt_fall;
   logic [CW-1:0] cnt;
   logic          period_end;
   logic [IW-1:0] icnt;

   assign s          = sync2 ^ INV_BIT;
   assign filt_edge  = (s != filt) && (fcnt == FCNT_LAST);
   assign filt_fall  = filt_edge && filt;
   assign period_end = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= SYNC_RST;
         sync2 <= SYNC_RST;
      end else begin
         sync1 <= ir_in;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt <= 1'b1;
         fcnt <= '0;
      end else if (s == filt) begin
         fcnt <= '0;
      end else if (fcnt == FCNT_LAST) begin
         filt <= s;
         fcnt <= '0;
      end else begin
         fcnt <= fcnt + FW'(1);
      end
   end

   // A filtered edge restarts the period at its midpoint so the next sample
   // lands half a period later; it also forces sample_clk low, never high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         ir_sample   <= 1'b1;
         sample_tick <= 1'b0;
         sample_clk  <= 1'b0;
      end else begin
         sample_tick <= period_end;
         if (period_end)
            ir_sample <= filt;

         if (filt_edge)
            cnt <= CNT_HALF;
         else if (period_end)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);

         if (filt_edge)
            sample_clk <= 1'b0;
         else if (cnt == CNT_RISE)
            sample_clk <= 1'b1;
         else if (period_end)
            sample_clk <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         icnt        <= '0;
         idle        <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         if (filt_edge)
            icnt <= '0;
         else if (sample_tick && filt && (icnt != IDLE_FULL))
            icnt <= icnt + IW'(1);
         idle        <= (icnt == IDLE_FULL);
         frame_start <= filt_fall && idle;
      end
   end

endmodule

// File: tb/tb_ir_frontend.sv
// Bench for ir_frontend: two instances (DIV=8 plain, DIV=4 inverted) checked every
// cycle against an event-time reference model, plus directed literal checks.
module tb_ir_frontend;

   typedef struct packed {
      int   n;     // clock edges since reset release
      int   run;   // consecutive clocks the synchronized level disagreed with filt
      int   t;     // edge at which the next sample update happens
      int   e;     // edge of the most recent realign
      int   hcnt;  // high-level ticks since last filtered edge (saturating)
      logic q1, q2, filt, samp, tick, sclk, idle, fs;
   } model_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ir0 = 1'b1;
   logic ir1 = 1'b0;
   logic samp0, sclk0, tick0, idle0, fs0;
   logic samp1, sclk1, tick1, idle1, fs1;
   int total = 0;
   int bad = 0;
   model_t m0, m1;
   logic collect = 1'b0;
   logic nec_q[$];

   always #5 clk = ~clk;

   ir_frontend #(.DIV(8), .FILT(3), .IDLE_TICKS(4), .INVERT(0)) u0 (
      .clk(clk), .reset(rst_n), .ir_in(ir0), .ir_sample(samp0), .sample_clk(sclk0),
      .sample_tick(tick0), .idle(idle0), .frame_start(fs0));

   ir_frontend #(.DIV(4), .FILT(3), .IDLE_TICKS(4), .INVERT(1)) u1 (
      .clk(clk), .reset(rst_n), .ir_in(ir1), .ir_sample(samp1), .sample_clk(sclk1),
      .sample_tick(tick1), .idle(idle1), .frame_start(fs1));

   function automatic model_t mreset(input int div);
      model_t r;
      r.n = 0; r.run = 0; r.t = div; r.e = 0; r.hcnt = 0;
      r.q1 = 1'b1; r.q2 = 1'b1; r.filt = 1'b1; r.samp = 1'b1;
      r.tick = 1'b0; r.sclk = 1'b0; r.idle = 1'b0; r.fs = 1'b0;
      return r;
   endfunction

   // Samples are scheduled in absolute time: every div edges, re-anchored half a
   // period after each filtered edge. sample_clk is high for the half period
   // preceding a sample, unless that half period began at or before a realign.
   function automatic model_t step(input model_t m, input logic ir, input int div,
                                   input int flen, input int idl, input logic inv);
      model_t r;
      logic fedge, fall;
      r = m;
      r.n = m.n + 1;
      fedge = 1'b0;
      fall = 1'b0;
      if (m.q2 != m.filt) begin
         r.run = m.run + 1;
         if (r.run >= flen) begin
            fedge = 1'b1;
            fall = m.filt;
            r.run = 0;
            r.filt = m.q2;
         end
      end else begin
         r.run = 0;
      end
      r.tick = (r.n == m.t);
      if (r.tick) r.samp = m.filt;
      if (fedge) begin
         r.t = r.n + div / 2;
         r.e = r.n;
      end else if (r.tick) begin
         r.t = m.t + div;
      end
      r.sclk = (r.n >= r.t - div / 2) && (r.t - div / 2 > r.e);
      if (fedge) r.hcnt = 0;
      else if (m.tick && m.filt && m.hcnt < idl) r.hcnt = m.hcnt + 1;
      r.idle = (m.hcnt >= idl);
      r.fs = fall && m.idle;
      r.q2 = m.q1;
      r.q1 = ir ^ inv;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0 <= mreset(8);
         m1 <= mreset(4);
      end else begin
         m0 <= step(m0, ir0, 8, 3, 4, 1'b0);
         m1 <= step(m1, ir1, 4, 3, 4, 1'b1);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("d0_ir_sample", samp0, m0.samp);
      chk("d0_sample_clk", sclk0, m0.sclk);
      chk("d0_sample_tick", tick0, m0.tick);
      chk("d0_idle", idle0, m0.idle);
      chk("d0_frame_start", fs0, m0.fs);
      chk("d1_ir_sample", samp1, m1.samp);
      chk("d1_sample_clk", sclk1, m1.sclk);
      chk("d1_sample_tick", tick1, m1.tick);
      chk("d1_idle", idle1, m1.idle);
      chk("d1_frame_start", fs1, m1.fs);
   end

   always @(negedge clk) begin
      if (collect && tick1) nec_q.push_back(samp1);
   end

   task automatic drv1(input logic v, input int clocks);
      ir1 = v;
      repeat (clocks) @(negedge clk);
   endtask

   initial begin
      int k, nt, fs_cnt, fs_at, samp_at, rise_at, lows, hold0, hold1;
      int tt[4];
      logic prev_sclk, found;
      logic [31:0] nec_word;

      // Reset and idle
      repeat (5) @(negedge clk);
      chk("rst_ir_sample", samp0, 1);
      chk("rst_sample_clk", sclk0, 0);
      chk("rst_idle", idle0, 0);
      rst_n = 1'b1;
      k = 0; nt = 0;
      for (int i = 0; i < 4; i++) tt[i] = 0;
      while (nt < 4 && k < 60) begin
         @(negedge clk);
         k++;
         if (tick0) begin
            tt[nt] = k;
            nt++;
         end
      end
      chk("tick_count", nt, 4);
      chk("first_tick", tt[0], 8);
      for (int i = 1; i < 4; i++) chk("tick_spacing", tt[i] - tt[i-1], 8);
      @(negedge clk);
      chk("idle_before", idle0, 0);
      @(negedge clk);
      chk("idle_after_4th", idle0, 1);
      chk("invert_idle", idle1, 1);

      // Glitch rejection
      ir0 = 1'b0;
      repeat (2) @(negedge clk);
      ir0 = 1'b1;
      fs_cnt = 0;
      k = 1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         fs_cnt += int'(fs0);
         if (!samp0 || !idle0) k = 0;
      end
      chk("glitch_no_fs", fs_cnt, 0);
      chk("glitch_level_idle", k, 1);

      // Frame start and alignment
      chk("pre_frame_idle", idle0, 1);
      ir0 = 1'b0;
      fs_cnt = 0; fs_at = -1; samp_at = -1; rise_at = -1;
      prev_sclk = sclk0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         fs_cnt += int'(fs0);
         if (fs0 && fs_at < 0) fs_at = i;
         if (i == 5) chk("idle_at_fs", idle0, 1);
         if (i == 6) chk("idle_after_fs", idle0, 0);
         if (!samp0 && samp_at < 0) samp_at = i;
         if (samp_at > 0 && i > samp_at && sclk0 && !prev_sclk && rise_at < 0) rise_at = i;
         prev_sclk = sclk0;
      end
      chk("fs_edge", fs_at, 5);
      chk("fs_once", fs_cnt, 1);
      chk("sample_low_at", samp_at, 9);
      chk("sclk_rise_at", rise_at, 13);
      ir0 = 1'b1;
      repeat (20) @(negedge clk);

      // Realign during sample_clk high phase (filtered edge with cnt = 6)
      found = 1'b0;
      for (int i = 0; i < 16 && !found; i++) begin
         @(negedge clk);
         if (tick0) found = 1'b1;
      end
      chk("realign_tick_found", found, 1);
      repeat (2) @(negedge clk);
      ir0 = 1'b0;
      repeat (4) @(negedge clk);
      chk("realign_sclk_high", sclk0, 1);
      @(negedge clk);
      chk("realign_sclk_fall", sclk0, 0);
      lows = 1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (sclk0) found = 1'b1;
         else lows++;
      end
      chk("realign_low_len", lows, 8);
      repeat (10) @(negedge clk);
      ir0 = 1'b1;
      repeat (30) @(negedge clk);

      // NEC frame into the inverted DIV=4 instance (ir1 = 1 is a carrier burst)
      nec_word = {8'hBA, 8'h45, 8'hFF, 8'h00};
      collect = 1'b1;
      drv1(1'b1, 64);
      drv1(1'b0, 32);
      for (int b = 0; b < 32; b++) begin
         drv1(1'b1, 4);
         drv1(1'b0, nec_word[b] ? 12 : 4);
      end
      drv1(1'b1, 4);
      drv1(1'b0, 80);
      collect = 1'b0;
      begin
         int idx, lz, lh, zbad, z, o;
         logic [31:0] got;
         idx = 0; lz = 0; lh = 0; zbad = 0; got = '0;
         while (idx < nec_q.size() && nec_q[idx] == 1'b1) idx++;
         while (idx < nec_q.size() && nec_q[idx] == 1'b0) begin lz++; idx++; end
         while (idx < nec_q.size() && nec_q[idx] == 1'b1) begin lh++; idx++; end
         for (int b = 0; b < 32; b++) begin
            z = 0; o = 0;
            while (idx < nec_q.size() && nec_q[idx] == 1'b0) begin z++; idx++; end
            while (idx < nec_q.size() && nec_q[idx] == 1'b1) begin o++; idx++; end
            if (z != 1) zbad++;
            got[b] = (o >= 2);
         end
         chk("nec_leader_low", lz, 16);
         chk("nec_leader_high", lh, 8);
         chk("nec_burst_len", zbad, 0);
         chk("nec_command", int'(got[23:16]), 'h45);
         chk("nec_word", int'(got == nec_word), 1);
      end

      // Randomized traffic on both instances
      hold0 = 0; hold1 = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold0 == 0) begin
            ir0 = 1'($urandom);
            hold0 = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 80) : $urandom_range(1, 12);
         end
         if (hold1 == 0) begin
            ir1 = 1'($urandom);
            hold1 = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
         end
         hold0--; hold1--;
         @(negedge clk);
      end

      // Mid-frame asynchronous reset
      ir0 = 1'b0; ir1 = 1'b1;
      repeat (20) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_d0_sample", samp0, 1);
      chk("mid_rst_d0_sclk", sclk0, 0);
      chk("mid_rst_d0_tick", tick0, 0);
      chk("mid_rst_d0_idle", idle0, 0);
      chk("mid_rst_d0_fs", fs0, 0);
      chk("mid_rst_d1_sample", samp1, 1);
      chk("mid_rst_d1_sclk", sclk1, 0);
      chk("mid_rst_d1_idle", idle1, 0);
      ir0 = 1'b1; ir1 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
